qpsk_frame_ctrl: RTL and testbench

- Receive-side frame controller after the IQ recombiner in the QPSK demodulator.
- Consumes the recovered serial bit stream and its per-bit valid strobe.
- Hunts for a sync word with a configurable error tolerance, then assembles the payload into bytes and delimits frames.
- Aborts to hunt on stream stall; drives downstream byte sinks (UART/FIFO).

---
 rtl/qpsk_frame_ctrl_pkg.sv | 17 +
 rtl/qpsk_frame_ctrl_if.sv | 21 ++
 rtl/qpsk_frame_ctrl_sync_corr.sv | 33 +++
 rtl/qpsk_frame_ctrl.sv | 179 +++++++++++++++++
 tb/tb_qpsk_frame_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/qpsk_frame_ctrl_pkg.sv
// rtl/qpsk_frame_ctrl_pkg.sv - shared types, defaults and helpers for the QPSK frame controller
package qpsk_frame_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hEB90;
  localparam int          SYNC_LEN_DEF  = 16;

  // Bits needed to hold a Hamming distance of 0..len.
  function automatic int dist_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/qpsk_frame_ctrl_if.sv
// rtl/qpsk_frame_ctrl_if.sv - bit-stream input and byte/frame output bundle of the frame controller
interface qpsk_frame_ctrl_if;
  logic       bit_i;
  logic       bit_vld_i;
  logic [7:0] byte_o;
  logic       byte_vld_o;
  logic       frame_start_o;
  logic       frame_end_o;
  logic       frame_err_o;
  logic       locked_o;

  modport slave (
    input  bit_i, bit_vld_i,
    output byte_o, byte_vld_o, frame_start_o, frame_end_o, frame_err_o, locked_o
  );

  modport master (
    output bit_i, bit_vld_i,
    input  byte_o, byte_vld_o, frame_start_o, frame_end_o, frame_err_o, locked_o
  );
endinterface

// File: rtl/qpsk_frame_ctrl_sync_corr.sv
// rtl/qpsk_frame_ctrl_sync_corr.sv - combinational Hamming-distance sync correlator
// Optional inverted-pattern output under QPSK_FRAME_INV_DET_EN.
module sync_corr
  import qpsk_frame_pkg::*;
#(
  parameter int                  SYNC_LEN  = SYNC_LEN_DEF,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int                  MAX_ERR   = 1
) (
  input  logic [SYNC_LEN-1:0] history,
  output logic                match
`ifdef QPSK_FRAME_INV_DET_EN
  ,
  output logic                inv_match
`endif
);

  localparam int DW = dist_width(SYNC_LEN);

  function automatic logic [DW-1:0] popcount(input logic [SYNC_LEN-1:0] v);
    logic [DW-1:0] c;
    c = '0;
    for (int i = 0; i < SYNC_LEN; i++) c = c + DW'(v[i]);
    return c;
  endfunction

  assign match = popcount(history ^ SYNC_WORD) <= DW'(MAX_ERR);

`ifdef QPSK_FRAME_INV_DET_EN
  assign inv_match = popcount(history ^ ~SYNC_WORD) <= DW'(MAX_ERR);
`endif

endmodule

// File: rtl/qpsk_frame_ctrl.sv
// rtl/qpsk_frame_ctrl.sv - sync hunt, byte assembly and frame delimiting after the IQ recombiner
// Optional 180-degree phase-ambiguity detection under QPSK_FRAME_INV_DET_EN.
module qpsk_frame_ctrl
  import qpsk_frame_pkg::*;
#(
  parameter int                  SYNC_LEN      = SYNC_LEN_DEF,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD     = SYNC_WORD_DEF,
  parameter int                  MAX_ERR       = 1,
  parameter int                  PAYLOAD_BYTES = 8,
  parameter int                  GAP_MAX       = 250
) (
  input  logic               clk,
  input  logic               rst_n,
  qpsk_frame_ctrl_if.slave   bus
);

  localparam int FW = dist_width(SYNC_LEN);
  localparam int GW = $clog2(GAP_MAX + 1);

  state_t              state_q, state_nxt;
  logic [SYNC_LEN-1:0] hist_q, hist_nxt, hist_shift;
  logic [FW-1:0]       fill_q, fill_nxt, fill_inc;
  logic [2:0]          bit_cnt_q, bit_cnt_nxt;
  logic [7:0]          byte_cnt_q, byte_cnt_nxt;
  logic [7:0]          shreg_q, shreg_nxt, shreg_shift;
  logic [GW-1:0]       gap_q, gap_nxt;
  logic [7:0]          byte_q, byte_nxt;
  logic                vld_q, vld_nxt;
  logic                start_q, start_nxt;
  logic                end_q, end_nxt;
  logic                err_q, err_nxt;
  logic                locked_q, locked_nxt;
  logic                bit_eff;
  logic                match;
  logic                any_match;

`ifdef QPSK_FRAME_INV_DET_EN
  logic inv_match;
  logic inv_q, inv_nxt;

  sync_corr #(.SYNC_LEN(SYNC_LEN), .SYNC_WORD(SYNC_WORD), .MAX_ERR(MAX_ERR)) u_corr (
    .history   (hist_shift),
    .match     (match),
    .inv_match (inv_match)
  );

  assign any_match = match | inv_match;
  assign bit_eff   = bus.bit_i ^ inv_q;
`else
  sync_corr #(.SYNC_LEN(SYNC_LEN), .SYNC_WORD(SYNC_WORD), .MAX_ERR(MAX_ERR)) u_corr (
    .history (hist_shift),
    .match   (match)
  );

  assign any_match = match;
  assign bit_eff   = bus.bit_i;
`endif

  assign hist_shift  = (hist_q << 1) | SYNC_LEN'(bus.bit_i);
  assign fill_inc    = (fill_q == FW'(SYNC_LEN)) ? fill_q : fill_q + 1'b1;
  assign shreg_shift = (shreg_q << 1) | 8'(bit_eff);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      hist_q     <= '0;
      fill_q     <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      gap_q      <= '0;
      byte_q     <= '0;
      vld_q      <= 1'b0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
`ifdef QPSK_FRAME_INV_DET_EN
      inv_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_nxt;
      hist_q     <= hist_nxt;
      fill_q     <= fill_nxt;
      bit_cnt_q  <= bit_cnt_nxt;
      byte_cnt_q <= byte_cnt_nxt;
      shreg_q    <= shreg_nxt;
      gap_q      <= gap_nxt;
      byte_q     <= byte_nxt;
      vld_q      <= vld_nxt;
      start_q    <= start_nxt;
      end_q      <= end_nxt;
      err_q      <= err_nxt;
      locked_q   <= locked_nxt;
`ifdef QPSK_FRAME_INV_DET_EN
      inv_q      <= inv_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state_q;
    hist_nxt     = hist_q;
    fill_nxt     = fill_q;
    bit_cnt_nxt  = bit_cnt_q;
    byte_cnt_nxt = byte_cnt_q;
    shreg_nxt    = shreg_q;
    gap_nxt      = gap_q;
    byte_nxt     = byte_q;
    vld_nxt      = 1'b0;
    start_nxt    = 1'b0;
    end_nxt      = 1'b0;
    err_nxt      = 1'b0;
`ifdef QPSK_FRAME_INV_DET_EN
    inv_nxt      = inv_q;
`endif
    case (state_q)
      HUNT: begin
        if (bus.bit_vld_i) begin
          hist_nxt = hist_shift;
          fill_nxt = fill_inc;
          // History is wiped on lock so the next hunt never reuses sync or payload bits.
          if (fill_inc == FW'(SYNC_LEN) && any_match) begin
            state_nxt    = PAYLOAD;
            start_nxt    = 1'b1;
            hist_nxt     = '0;
            fill_nxt     = '0;
            bit_cnt_nxt  = '0;
            byte_cnt_nxt = '0;
            gap_nxt      = '0;
`ifdef QPSK_FRAME_INV_DET_EN
            inv_nxt      = ~match;
`endif
          end
        end
      end
      PAYLOAD: begin
        if (bus.bit_vld_i) begin
          gap_nxt   = '0;
          shreg_nxt = shreg_shift;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_nxt  = '0;
            byte_nxt     = shreg_shift;
            vld_nxt      = 1'b1;
            byte_cnt_nxt = byte_cnt_q + 8'd1;
            if (byte_cnt_q == 8'(PAYLOAD_BYTES - 1)) begin
              end_nxt   = 1'b1;
              state_nxt = HUNT;
`ifdef QPSK_FRAME_INV_DET_EN
              inv_nxt   = 1'b0;
`endif
            end
          end else begin
            bit_cnt_nxt = bit_cnt_q + 3'd1;
          end
        end else if (gap_q == GW'(GAP_MAX - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = HUNT;
          gap_nxt   = '0;
`ifdef QPSK_FRAME_INV_DET_EN
          inv_nxt   = 1'b0;
`endif
        end else begin
          gap_nxt = gap_q + 1'b1;
        end
      end
      default: state_nxt = HUNT;
    endcase
    locked_nxt = (state_nxt == PAYLOAD);
  end

  assign bus.byte_o        = byte_q;
  assign bus.byte_vld_o    = vld_q;
  assign bus.frame_start_o = start_q;
  assign bus.frame_end_o   = end_q;
  assign bus.frame_err_o   = err_q;
  assign bus.locked_o      = locked_q;

endmodule

// File: tb/tb_qpsk_frame_ctrl.sv
// tb/tb_qpsk_frame_ctrl.sv - self-checking bench for qpsk_frame_ctrl against an event-level stream model
module tb_qpsk_frame_ctrl;

  localparam int          GAP_MAX = 250;
  localparam int          PB      = 8;
  localparam int          MAX_ERR = 1;
  localparam logic [15:0] SYNC    = 16'hEB90;

  typedef struct {int k; int t; int v;} ev_t;       // k: 0 start, 1 byte, 2 end, 3 err
  typedef struct {int t; logic b; bit rst;} ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   last_strobe_t = 0;

  ev_t  act_q[$];
  ev_t  exp_q[$];
  ent_t ent_q[$];
  logic [7:0] pay [8];

  bit         m_locked = 0;
  bit         m_inv = 0;
  logic [15:0] m_win = '0;
  int         m_fill = 0;
  int         m_nbits = 0;
  int         m_nbytes = 0;
  int         m_last = 0;
  logic [7:0] m_acc = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qpsk_frame_ctrl_if bus();

  qpsk_frame_ctrl #(
    .SYNC_LEN(16), .SYNC_WORD(SYNC), .MAX_ERR(MAX_ERR),
    .PAYLOAD_BYTES(PB), .GAP_MAX(GAP_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) begin
    #1;
    if (bus.frame_start_o === 1'b1) act_q.push_back('{0, cyc, 0});
    if (bus.byte_vld_o === 1'b1)    act_q.push_back('{1, cyc, int'(bus.byte_o)});
    if (bus.frame_end_o === 1'b1)   act_q.push_back('{2, cyc, 0});
    if (bus.frame_err_o === 1'b1)   act_q.push_back('{3, cyc, 0});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic b, input int sp);
    idle(sp - 1);
    bus.bit_i     = b;
    bus.bit_vld_i = 1'b1;
    ent_q.push_back('{cyc + 1, b, 1'b0});
    last_strobe_t = cyc + 1;
    idle(1);
    bus.bit_vld_i = 1'b0;
    bus.bit_i     = 1'($urandom);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input int sp);
    for (int i = n - 1; i >= 0; i--)
      strobe(v[i], (sp == 0) ? int'($urandom_range(1, 20)) : sp);
  endtask

  task automatic send_payload(input int first, input int last, input int sp, input bit inv);
    for (int i = first; i <= last; i++) send_bits({24'd0, pay[i] ^ {8{inv}}}, 8, sp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ent_q.push_back('{cyc + 1, 1'b0, 1'b1});
    idle(1);
    rst_n = 1'b1;
    check("rst_byte", bus.byte_o, 0);
    check("rst_vld", bus.byte_vld_o, 0);
    check("rst_start", bus.frame_start_o, 0);
    check("rst_end", bus.frame_end_o, 0);
    check("rst_err", bus.frame_err_o, 0);
    check("rst_lock", bus.locked_o, 0);
  endtask

  task automatic m_lock(input int t, input bit inv);
    exp_q.push_back('{0, t, 0});
    m_locked = 1; m_inv = inv; m_win = '0; m_fill = 0;
    m_nbits = 0; m_nbytes = 0; m_last = t;
  endtask

  task automatic m_abort();
    exp_q.push_back('{3, m_last + GAP_MAX, 0});
    m_locked = 0; m_inv = 0;
  endtask

  // Stream-level model: window matching on the raw bit sequence, byte grouping by count.
  task automatic model_run(input int t_end);
    ent_t e;
    while (ent_q.size() > 0) begin
      e = ent_q.pop_front();
      if (m_locked && e.t > m_last + GAP_MAX) m_abort();
      if (e.rst) begin
        m_locked = 0; m_inv = 0; m_win = '0; m_fill = 0;
        continue;
      end
      if (!m_locked) begin
        m_win = {m_win[14:0], e.b};
        if (m_fill < 16) m_fill++;
        if (m_fill == 16) begin
          if ($countones(m_win ^ SYNC) <= MAX_ERR) m_lock(e.t, 0);
`ifdef QPSK_FRAME_INV_DET_EN
          else if ($countones(m_win ^ ~SYNC) <= MAX_ERR) m_lock(e.t, 1);
`endif
        end
      end else begin
        m_acc = {m_acc[6:0], e.b ^ m_inv};
        m_nbits++;
        m_last = e.t;
        if (m_nbits == 8) begin
          exp_q.push_back('{1, e.t, int'(m_acc)});
          m_nbits = 0;
          m_nbytes++;
          if (m_nbytes == PB) begin
            exp_q.push_back('{2, e.t, 0});
            m_locked = 0; m_inv = 0;
          end
        end
      end
    end
    if (m_locked && t_end >= m_last + GAP_MAX) m_abort();
  endtask

  task automatic close_seg(input string tag, output int ns, output int ne, output int nerr);
    int n;
    idle(300);
    model_run(cyc);
    ns = 0; ne = 0; nerr = 0;
    foreach (act_q[i]) begin
      if (act_q[i].k == 0) ns++;
      if (act_q[i].k == 2) ne++;
      if (act_q[i].k == 3) nerr++;
    end
    check({tag, "_nev"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_kind%0d", tag, i), act_q[i].k, exp_q[i].k);
      check($sformatf("%s_time%0d", tag, i), act_q[i].t, exp_q[i].t);
      check($sformatf("%s_val%0d", tag, i), act_q[i].v, exp_q[i].v);
    end
    check({tag, "_lock"}, bus.locked_o, m_locked);
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int ns, ne, nerr;
    logic [15:0] sw;
    bus.bit_i     = 1'b0;
    bus.bit_vld_i = 1'b0;
    rst_n         = 1'b0;
    idle(3);
    rst_n = 1'b1;
    check("init_byte", bus.byte_o, 0);
    check("init_vld", bus.byte_vld_o, 0);
    check("init_start", bus.frame_start_o, 0);
    check("init_end", bus.frame_end_o, 0);
    check("init_err", bus.frame_err_o, 0);
    check("init_lock", bus.locked_o, 0);

    for (int i = 0; i < 8; i++) pay[i] = 8'(i + 1);
    send_bits({16'd0, SYNC}, 16, 100);
    send_payload(0, 7, 100, 0);
    close_seg("clean", ns, ne, nerr);
    check("clean_starts", ns, 1);
    check("clean_ends", ne, 1);
    check("clean_hold", bus.byte_o, 8'h08);

    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    send_bits({16'd0, 16'hEB91}, 16, 0);
    send_payload(0, 7, 0, 0);
    close_seg("tol1", ns, ne, nerr);
    check("tol1_starts", ns, 1);

    for (int i = 0; i < 8; i++) pay[i] = 8'(i + 1);
    send_bits({16'd0, 16'hEB93}, 16, 0);
    send_payload(0, 7, 0, 0);
    close_seg("tol2", ns, ne, nerr);
    check("tol2_starts", ns, 0);

    send_bits({16'd0, SYNC}, 16, 0);
    send_payload(0, 2, 0, 0);
    send_bits({28'd0, pay[3][7:4]}, 4, 0);
    check("gap_locked", bus.locked_o, 1);
    idle(300);
    foreach (act_q[i])
      if (act_q[i].k == 3) check("gap_delay", act_q[i].t - last_strobe_t, GAP_MAX);
    close_seg("gap", ns, ne, nerr);
    check("gap_errs", nerr, 1);
    check("gap_ends", ne, 0);
    send_bits({16'd0, SYNC}, 16, 0);
    send_payload(0, 7, 0, 0);
    close_seg("relock", ns, ne, nerr);
    check("relock_starts", ns, 1);

    pay[0] = 8'hEB; pay[1] = 8'h90;
    for (int i = 2; i < 8; i++) pay[i] = 8'($urandom);
    for (int f = 0; f < 2; f++) begin
      send_bits({16'd0, SYNC}, 16, 1);
      send_payload(0, 7, 1, 0);
    end
    close_seg("b2b", ns, ne, nerr);
    check("b2b_starts", ns, 2);
    check("b2b_ends", ne, 2);

    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    send_bits({16'd0, SYNC}, 16, 0);
    send_payload(0, 3, 0, 0);
    send_bits({29'd0, pay[4][7:5]}, 3, 0);
    do_reset();
    send_bits({27'd0, pay[4][4:0]}, 5, 0);
    send_payload(5, 7, 0, 0);
    close_seg("mrst", ns, ne, nerr);
    check("mrst_ends", ne, 0);
    send_bits({16'd0, SYNC}, 16, 0);
    send_payload(0, 7, 0, 0);
    close_seg("mrst_relock", ns, ne, nerr);
    check("mrst_relock_ends", ne, 1);

    for (int i = 0; i < 8; i++) pay[i] = 8'(i + 1);
    send_bits({16'd0, 16'h146F}, 16, 0);
    send_payload(0, 7, 0, 1);
    close_seg("inv", ns, ne, nerr);
`ifdef QPSK_FRAME_INV_DET_EN
    check("inv_starts", ns, 1);
`else
    check("inv_starts", ns, 0);
`endif

    for (int r = 0; r < 4; r++) begin
      sw = SYNC;
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) sw[$urandom_range(0, 15)] ^= 1'b1;
      for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
      send_bits({16'd0, sw}, 16, 0);
      send_payload(0, 7, 0, 0);
      close_seg($sformatf("rnd%0d", r), ns, ne, nerr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
